// File: rtl/shift_frame_ctrl_pkg.sv
// Shared types and constants for the camera-shift frame sequencer.
// Holds the FSM encoding, count widths, default thresholds and the saturating increment.
package shift_frame_ctrl_pkg;

    localparam int unsigned CNT_W = 5;
    localparam int unsigned HYS_W = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [HYS_W-1:0] HYS_MAX = '1;

    localparam int unsigned DEF_SHIFT_SAME  = 9;
    localparam int unsigned DEF_SHIFT_X_BIG = 13;
    localparam int unsigned DEF_SHIFT_Y_BIG = 15;
    localparam int unsigned DEF_N_ON        = 2;
    localparam int unsigned DEF_N_OFF       = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_EVAL   = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] dxo;
        logic [CNT_W-1:0] dxn;
        logic [CNT_W-1:0] dyo;
        logic [CNT_W-1:0] dyn;
    } counts_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/shift_decide.sv
// Combinational shift rule applied to one frame's latched displacement counts.
// All threshold comparisons are strictly greater-than on unsigned counts.
module shift_decide
    import shift_frame_ctrl_pkg::*;
#(
    parameter int unsigned SHIFT_SAME  = DEF_SHIFT_SAME,
    parameter int unsigned SHIFT_X_BIG = DEF_SHIFT_X_BIG,
    parameter int unsigned SHIFT_Y_BIG = DEF_SHIFT_Y_BIG
) (
    input  logic [CNT_W-1:0] dxo_i,
    input  logic [CNT_W-1:0] dxn_i,
    input  logic [CNT_W-1:0] dyo_i,
    input  logic [CNT_W-1:0] dyn_i,
    input  logic             x_same_i,
    input  logic             y_same_i,
    output logic             shift_o
);

    logic x_pair;
    logic y_pair;
    logic big_any;

    always_comb begin
        x_pair  = (dxo_i > CNT_W'(SHIFT_SAME)) && (dxn_i > CNT_W'(SHIFT_SAME)) && x_same_i;
        y_pair  = (dyo_i > CNT_W'(SHIFT_SAME)) && (dyn_i > CNT_W'(SHIFT_SAME)) && y_same_i;
        big_any = (dxo_i > CNT_W'(SHIFT_X_BIG)) || (dxn_i > CNT_W'(SHIFT_X_BIG)) ||
                  (dyo_i > CNT_W'(SHIFT_Y_BIG)) || (dyn_i > CNT_W'(SHIFT_Y_BIG));
        shift_o = x_pair || y_pair || big_any;
    end

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer: counts displacement events per frame, evaluates the shift rule
// at frame end and filters the per-frame decision with on/off hysteresis.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for frame_start, events ignored
// ST_ACCUM  | counting events, waiting for frame_end
// ST_EVAL   | one cycle: counts and decision latched into output registers
// ST_REPORT | one cycle: result_valid, new results visible
module shift_frame_ctrl
    import shift_frame_ctrl_pkg::*;
#(
    parameter int unsigned SHIFT_SAME  = DEF_SHIFT_SAME,
    parameter int unsigned SHIFT_X_BIG = DEF_SHIFT_X_BIG,
    parameter int unsigned SHIFT_Y_BIG = DEF_SHIFT_Y_BIG,
    parameter int unsigned N_ON        = DEF_N_ON,
    parameter int unsigned N_OFF       = DEF_N_OFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             ev_dxo,
    input  logic             ev_dxn,
    input  logic             ev_dyo,
    input  logic             ev_dyn,
    input  logic             x_same,
    input  logic             y_same,
    output logic             busy,
    output logic             frame_shift,
    output logic             shift_flag,
    output logic             result_valid,
    output logic [CNT_W-1:0] cnt_dxo,
    output logic [CNT_W-1:0] cnt_dxn,
    output logic [CNT_W-1:0] cnt_dyo,
    output logic [CNT_W-1:0] cnt_dyn
);

    state_e           state_q, state_d;
    counts_t          live_q, live_d;
    counts_t          live_inc;
    counts_t          cnt_q, cnt_d;
    logic             x_same_q, x_same_d;
    logic             y_same_q, y_same_d;
    logic             frame_shift_q, frame_shift_d;
    logic             shift_flag_q, shift_flag_d;
    logic [HYS_W-1:0] on_cnt_q, on_cnt_d;
    logic [HYS_W-1:0] off_cnt_q, off_cnt_d;
    logic             decide_shift;

    // Decision is taken from the live counters during EVAL, which are exactly what gets copied.
    shift_decide #(
        .SHIFT_SAME  (SHIFT_SAME),
        .SHIFT_X_BIG (SHIFT_X_BIG),
        .SHIFT_Y_BIG (SHIFT_Y_BIG)
    ) u_decide (
        .dxo_i    (live_q.dxo),
        .dxn_i    (live_q.dxn),
        .dyo_i    (live_q.dyo),
        .dyn_i    (live_q.dyn),
        .x_same_i (x_same_q),
        .y_same_i (y_same_q),
        .shift_o  (decide_shift)
    );

    always_comb begin
        live_inc.dxo = sat_inc(live_q.dxo, ev_dxo);
        live_inc.dxn = sat_inc(live_q.dxn, ev_dxn);
        live_inc.dyo = sat_inc(live_q.dyo, ev_dyo);
        live_inc.dyn = sat_inc(live_q.dyn, ev_dyn);
    end

    always_comb begin
        state_d       = state_q;
        live_d        = live_q;
        cnt_d         = cnt_q;
        x_same_d      = x_same_q;
        y_same_d      = y_same_q;
        frame_shift_d = frame_shift_q;
        shift_flag_d  = shift_flag_q;
        on_cnt_d      = on_cnt_q;
        off_cnt_d     = off_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_ACCUM;
                    live_d  = '0;
                end
            end
            ST_ACCUM: begin
                // frame_end has priority over a coincident frame_start.
                if (frame_end) begin
                    live_d   = live_inc;
                    x_same_d = x_same;
                    y_same_d = y_same;
                    state_d  = ST_EVAL;
                end else if (frame_start) begin
                    live_d = '0;
                end else begin
                    live_d = live_inc;
                end
            end
            ST_EVAL: begin
                cnt_d         = live_q;
                frame_shift_d = decide_shift;
                if (decide_shift) begin
                    on_cnt_d  = (on_cnt_q == HYS_MAX) ? on_cnt_q : on_cnt_q + 1'b1;
                    off_cnt_d = '0;
                    if (on_cnt_d >= HYS_W'(N_ON)) begin
                        shift_flag_d = 1'b1;
                    end
                end else begin
                    off_cnt_d = (off_cnt_q == HYS_MAX) ? off_cnt_q : off_cnt_q + 1'b1;
                    on_cnt_d  = '0;
                    if (off_cnt_d >= HYS_W'(N_OFF)) begin
                        shift_flag_d = 1'b0;
                    end
                end
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (frame_start) begin
                    state_d = ST_ACCUM;
                    live_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            live_q        <= '0;
            cnt_q         <= '0;
            x_same_q      <= 1'b0;
            y_same_q      <= 1'b0;
            frame_shift_q <= 1'b0;
            shift_flag_q  <= 1'b0;
            on_cnt_q      <= '0;
            off_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            live_q        <= live_d;
            cnt_q         <= cnt_d;
            x_same_q      <= x_same_d;
            y_same_q      <= y_same_d;
            frame_shift_q <= frame_shift_d;
            shift_flag_q  <= shift_flag_d;
            on_cnt_q      <= on_cnt_d;
            off_cnt_q     <= off_cnt_d;
        end
    end

    assign busy         = (state_q == ST_ACCUM) || (state_q == ST_EVAL);
    assign result_valid = (state_q == ST_REPORT);
    assign frame_shift  = frame_shift_q;
    assign shift_flag   = shift_flag_q;
    assign cnt_dxo      = cnt_q.dxo;
    assign cnt_dxn      = cnt_q.dxn;
    assign cnt_dyo      = cnt_q.dyo;
    assign cnt_dyn      = cnt_q.dyn;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed bench for shift_frame_ctrl: frame vectors with hand-computed counts,
// decisions and hysteresis state under the default thresholds.
module tb_shift_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       ev_dxo = 1'b0;
    logic       ev_dxn = 1'b0;
    logic       ev_dyo = 1'b0;
    logic       ev_dyn = 1'b0;
    logic       x_same = 1'b0;
    logic       y_same = 1'b0;
    logic       busy;
    logic       frame_shift;
    logic       shift_flag;
    logic       result_valid;
    logic [4:0] cnt_dxo;
    logic [4:0] cnt_dxn;
    logic [4:0] cnt_dyo;
    logic [4:0] cnt_dyn;

    int n_total = 0;
    int n_pass  = 0;
    int rv_count = 0;

    shift_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .ev_dxo       (ev_dxo),
        .ev_dxn       (ev_dxn),
        .ev_dyo       (ev_dyo),
        .ev_dyn       (ev_dyn),
        .x_same       (x_same),
        .y_same       (y_same),
        .busy         (busy),
        .frame_shift  (frame_shift),
        .shift_flag   (shift_flag),
        .result_valid (result_valid),
        .cnt_dxo      (cnt_dxo),
        .cnt_dxn      (cnt_dxn),
        .cnt_dyo      (cnt_dyo),
        .cnt_dyn      (cnt_dyn)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid) rv_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    task automatic run_events(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        for (int i = 0; i < m; i++) begin
            ev_dxo = (i < a);
            ev_dxn = (i < b);
            ev_dyo = (i < c);
            ev_dyn = (i < d);
            cycle();
        end
        {ev_dxo, ev_dxn, ev_dyo, ev_dyn} = 4'b0;
    endtask

    // Drives the frame_end cycle and waits (bounded) for result_valid; checks the 2-cycle latency.
    task automatic end_frame(input string tag, input logic xs, input logic ys,
                             input logic all_ev, input logic with_start);
        int lat;
        frame_end   = 1'b1;
        frame_start = with_start;
        x_same      = xs;
        y_same      = ys;
        {ev_dxo, ev_dxn, ev_dyo, ev_dyn} = {4{all_ev}};
        cycle();
        frame_end   = 1'b0;
        frame_start = 1'b0;
        x_same      = 1'b0;
        y_same      = 1'b0;
        {ev_dxo, ev_dxn, ev_dyo, ev_dyn} = 4'b0;
        lat = 0;
        while (!result_valid && lat < 8) begin
            cycle();
            lat++;
        end
        chk({tag, " latency"}, lat, 1);
    endtask

    task automatic do_frame(input string tag, input int a, input int b, input int c, input int d,
                            input logic xs, input logic ys, input int exp_fs, input int exp_flag);
        start_frame();
        run_events(a, b, c, d);
        end_frame(tag, xs, ys, 1'b0, 1'b0);
        chk({tag, " frame_shift"}, frame_shift, exp_fs);
        chk({tag, " shift_flag"}, shift_flag, exp_flag);
        cycle();
        chk({tag, " rv one cycle"}, result_valid, 0);
        cycle();
    endtask

    initial begin
        int rv_before;
        repeat (3) cycle();
        chk("reset busy", busy, 0);
        chk("reset frame_shift", frame_shift, 0);
        chk("reset shift_flag", shift_flag, 0);
        chk("reset result_valid", result_valid, 0);
        chk("reset cnts", {cnt_dxo, cnt_dxn, cnt_dyo, cnt_dyn}, 0);
        rst = 1'b0;
        cycle();

        // events in IDLE are ignored
        run_events(3, 3, 3, 3);
        chk("idle busy", busy, 0);

        do_frame("f1 dxo14", 14, 0, 0, 0, 1'b0, 1'b0, 1, 0);
        chk("f1 cnt_dxo", cnt_dxo, 14);
        chk("f1 cnt_dxn", cnt_dxn, 0);
        do_frame("f2 dxo14", 14, 0, 0, 0, 1'b0, 1'b0, 1, 1);
        do_frame("f3 x pair", 10, 10, 0, 0, 1'b1, 1'b0, 1, 1);
        do_frame("f4 x pair nosame", 10, 10, 0, 0, 1'b0, 1'b0, 0, 1);
        do_frame("f5 dxo9 bound", 9, 10, 0, 0, 1'b1, 1'b0, 0, 1);
        chk("f5 cnt_dxo", cnt_dxo, 9);
        chk("f5 cnt_dxn", cnt_dxn, 10);
        do_frame("f6 quiet", 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);

        // 40 dyo pulses plus all four events on the frame_end cycle
        start_frame();
        chk("accum busy", busy, 1);
        run_events(0, 0, 40, 0);
        end_frame("f7 sat", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("f7 cnt_dyo", cnt_dyo, 31);
        chk("f7 cnt_dxo", cnt_dxo, 1);
        chk("f7 cnt_dxn", cnt_dxn, 1);
        chk("f7 cnt_dyn", cnt_dyn, 1);
        chk("f7 frame_shift", frame_shift, 1);
        chk("f7 shift_flag", shift_flag, 0);
        repeat (2) cycle();

        do_frame("f8 quiet", 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        do_frame("f9 y pair", 0, 0, 10, 10, 1'b0, 1'b1, 1, 0);
        do_frame("f10 dyn16", 0, 0, 0, 16, 1'b0, 1'b0, 1, 1);
        do_frame("f11 dyn15 bound", 0, 0, 0, 15, 1'b0, 1'b0, 0, 1);
        do_frame("f12 dxn13 bound", 0, 13, 0, 0, 1'b0, 1'b0, 0, 1);
        do_frame("f13 dxn14", 0, 14, 0, 0, 1'b0, 1'b0, 1, 1);
        chk("f13 cnt_dxn", cnt_dxn, 14);
        chk("hold cnt_dxn", cnt_dxn, 14);

        // aborted frame: restart mid-ACCUM, then an empty frame
        rv_before = rv_count;
        start_frame();
        run_events(12, 0, 0, 0);
        start_frame();
        end_frame("abort", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort cnt_dxo", cnt_dxo, 0);
        chk("abort frame_shift", frame_shift, 0);
        chk("abort shift_flag", shift_flag, 1);
        repeat (3) cycle();
        chk("abort rv count", rv_count - rv_before, 1);

        // frame_start coincident with frame_end: evaluates, new frame not started
        start_frame();
        run_events(5, 0, 0, 0);
        end_frame("coincident", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("coincident cnt_dxo", cnt_dxo, 5);
        cycle();
        chk("coincident idle", busy, 0);
        cycle();

        // reset mid-ACCUM discards the frame and the hysteresis state
        rv_before = rv_count;
        start_frame();
        run_events(20, 0, 0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst shift_flag", shift_flag, 0);
        chk("rst cnt_dxo", cnt_dxo, 0);
        chk("rst frame_shift", frame_shift, 0);
        frame_end = 1'b1;
        cycle();
        frame_end = 1'b0;
        repeat (4) cycle();
        chk("rst no rv", rv_count - rv_before, 0);
        do_frame("post rst 1", 14, 0, 0, 0, 1'b0, 1'b0, 1, 0);
        chk("post rst cnt_dxo", cnt_dxo, 14);
        do_frame("post rst 2", 14, 0, 0, 0, 1'b0, 1'b0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
